// File: rtl/jpeg_hdmi_pkg.sv
// Shared definitions for the JPEG-decoder to HDMI block path.
//   BLOCK_SIZE       : edge length of a decoded block in pixels.
//   beats_per_blk()  : beats needed to move one 8x8 block at n pixels/beat.
//   blks_per_stripe(): blocks across one 8-line stripe.
//   stripes()        : 8-line stripes per frame.
//   cnt_width()      : index width for a 0..n-1 counter, never below 1 bit.
//   sched_state_e    : block scheduler FSM states.
package jpeg_hdmi_pkg;

    localparam int BLOCK_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_CREDIT = 2'd1,
        STREAM      = 2'd2,
        FRAME_END   = 2'd3
    } sched_state_e;

    function automatic int beats_per_blk(input int n);
        return (BLOCK_SIZE * BLOCK_SIZE) / n;
    endfunction

    function automatic int blks_per_stripe(input int x_res);
        return x_res / BLOCK_SIZE;
    endfunction

    function automatic int stripes(input int y_res);
        return y_res / BLOCK_SIZE;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blk_stripe_scheduler_if.sv
// Block stream bundle between the JPEG decoder, the stripe scheduler and the
// block-to-raster converter.
//   in_*  : decoder beat stream. A beat transfers in every cycle where
//           in_valid && in_ready are both high; in_ready never depends on
//           in_valid, and in_data_* only matter while in_valid is high.
//   blk_* : converter beat stream, valid-only (no back-pressure); blk_data_*
//           and the sob/eob/sof markers only matter while blk_valid is high.
// master drives the decoder side and observes the converter side; slave is
// the scheduler.
interface blk_stripe_scheduler_if #(
    parameter int N = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [N-1:0][7:0] in_data_y;
    logic signed [N-1:0][7:0] in_data_cr;
    logic signed [N-1:0][7:0] in_data_cb;

    logic                     blk_valid;
    logic signed [N-1:0][7:0] blk_data_y;
    logic signed [N-1:0][7:0] blk_data_cr;
    logic signed [N-1:0][7:0] blk_data_cb;
    logic                     blk_sob;
    logic                     blk_eob;
    logic                     blk_sof;

    modport master (
        output in_valid, in_data_y, in_data_cr, in_data_cb,
        input  in_ready,
        input  blk_valid, blk_data_y, blk_data_cr, blk_data_cb,
        input  blk_sob, blk_eob, blk_sof
    );

    modport slave (
        input  in_valid, in_data_y, in_data_cr, in_data_cb,
        output in_ready,
        output blk_valid, blk_data_y, blk_data_cr, blk_data_cb,
        output blk_sob, blk_eob, blk_sof
    );
endinterface

// File: rtl/stripe_credit_cntr.sv
// Saturating up/down counter for stripe-buffer bookkeeping.
//   clk, rst_n : clock, asynchronous active-low reset (count resets to MAX).
//   inc        : one buffer returned (count up, saturates at MAX).
//   dec        : one buffer claimed (count down, holds at 0).
//   count      : current number of free buffers.
//   overflow   : sticky; set when inc arrives alone while count == MAX.
module stripe_credit_cntr #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow
);
    localparam logic [W-1:0] FULL = W'(MAX);

    logic [W-1:0] count_q, count_d;
    logic         overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        // Simultaneous inc and dec cancel out and never flag an overflow.
        if (inc && !dec) begin
            if (count_q == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= FULL;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;
endmodule

// File: rtl/blk_stripe_scheduler.sv
// Frames the decoded block stream for the block-to-raster converter and paces
// it with stripe credits so the converter's stripe buffers are never
// overwritten before they drain.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   enable      : run request, sampled only in IDLE and FRAME_END.
//   bus         : in_* decoder stream (valid/ready), blk_* converter stream
//                 (registered, one cycle behind the accepted beat).
//   stripe_done : pulse, downstream freed one stripe buffer.
//   frame_done  : pulse, the cycle after FRAME_END.
//   busy        : FSM is not IDLE.
//   err_credit  : sticky, stripe_done arrived with all credits already held.
//   dbg_state   : current FSM state.
module blk_stripe_scheduler
    import jpeg_hdmi_pkg::*;
#(
    parameter int N       = 2,
    parameter int X_RES   = 2160,
    parameter int Y_RES   = 1200,
    parameter int CREDITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    blk_stripe_scheduler_if.slave bus,
    input  logic                  stripe_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_credit,
    output sched_state_e          dbg_state
);
    localparam int N_BEATS   = beats_per_blk(N);
    localparam int N_BLKS    = blks_per_stripe(X_RES);
    localparam int N_STRIPES = stripes(Y_RES);
    localparam int EW        = cnt_width(N_BEATS);
    localparam int BW        = cnt_width(N_BLKS);
    localparam int SW        = cnt_width(N_STRIPES);
    localparam int CW        = $clog2(CREDITS + 1);

    localparam logic [EW-1:0] ELEM_LAST   = EW'(N_BEATS - 1);
    localparam logic [BW-1:0] BLK_LAST    = BW'(N_BLKS - 1);
    localparam logic [SW-1:0] STRIPE_LAST = SW'(N_STRIPES - 1);

    sched_state_e             state_q, state_d;
    logic [EW-1:0]            elem_q, elem_d;
    logic [BW-1:0]            blk_q, blk_d;
    logic [SW-1:0]            stripe_q, stripe_d;
    logic                     blk_valid_q, blk_valid_d;
    logic signed [N-1:0][7:0] y_q, y_d, cr_q, cr_d, cb_q, cb_d;
    logic                     sob_q, sob_d, eob_q, eob_d, sof_q, sof_d;
    logic                     frame_done_q, frame_done_d;

    logic [CW-1:0]            credits;
    logic                     accept, consume;
    logic                     end_blk, end_stripe, end_frame;

    stripe_credit_cntr #(
        .MAX (CREDITS),
        .W   (CW)
    ) u_credits (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (stripe_done),
        .dec      (consume),
        .count    (credits),
        .overflow (err_credit)
    );

    always_comb begin
        accept     = bus.in_valid && (state_q == STREAM);
        // A credit is claimed only on the WAIT_CREDIT -> STREAM transition,
        // so the counter can never be asked to go below zero.
        consume    = (state_q == WAIT_CREDIT) && (credits != '0);
        end_blk    = (elem_q == ELEM_LAST);
        end_stripe = end_blk && (blk_q == BLK_LAST);
        end_frame  = end_stripe && (stripe_q == STRIPE_LAST);

        state_d  = state_q;
        elem_d   = elem_q;
        blk_d    = blk_q;
        stripe_d = stripe_q;

        case (state_q)
            IDLE:        if (enable) state_d = WAIT_CREDIT;
            WAIT_CREDIT: if (consume) state_d = STREAM;
            STREAM: begin
                if (accept && end_stripe) begin
                    state_d = end_frame ? FRAME_END : WAIT_CREDIT;
                end
            end
            FRAME_END:   state_d = enable ? WAIT_CREDIT : IDLE;
            default:     state_d = IDLE;
        endcase

        if (accept) begin
            elem_d = end_blk ? '0 : elem_q + EW'(1);
            if (end_blk) begin
                blk_d = end_stripe ? '0 : blk_q + BW'(1);
            end
            if (end_stripe) begin
                stripe_d = end_frame ? '0 : stripe_q + SW'(1);
            end
        end

        // Output stage mirrors the accept cycle one clock later.
        blk_valid_d  = accept;
        y_d          = bus.in_data_y;
        cr_d         = bus.in_data_cr;
        cb_d         = bus.in_data_cb;
        sob_d        = accept && (elem_q == '0);
        eob_d        = accept && end_blk;
        sof_d        = accept && (elem_q == '0) && (blk_q == '0) && (stripe_q == '0);
        frame_done_d = (state_q == FRAME_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            elem_q       <= '0;
            blk_q        <= '0;
            stripe_q     <= '0;
            blk_valid_q  <= 1'b0;
            y_q          <= '0;
            cr_q         <= '0;
            cb_q         <= '0;
            sob_q        <= 1'b0;
            eob_q        <= 1'b0;
            sof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            blk_q        <= blk_d;
            stripe_q     <= stripe_d;
            blk_valid_q  <= blk_valid_d;
            y_q          <= y_d;
            cr_q         <= cr_d;
            cb_q         <= cb_d;
            sob_q        <= sob_d;
            eob_q        <= eob_d;
            sof_q        <= sof_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready    = (state_q == STREAM);
    assign bus.blk_valid   = blk_valid_q;
    assign bus.blk_data_y  = y_q;
    assign bus.blk_data_cr = cr_q;
    assign bus.blk_data_cb = cb_q;
    assign bus.blk_sob     = sob_q;
    assign bus.blk_eob     = eob_q;
    assign bus.blk_sof     = sof_q;
    assign frame_done      = frame_done_q;
    assign busy            = (state_q != IDLE);
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_blk_stripe_scheduler.sv
// Directed bench for blk_stripe_scheduler with an 16x16 frame:
// 32 beats/block, 2 blocks/stripe, 2 stripes, 128 beats/frame.
module tb_blk_stripe_scheduler;
    import jpeg_hdmi_pkg::*;

    localparam int N       = 2;
    localparam int X_RES   = 16;
    localparam int Y_RES   = 16;
    localparam int CREDITS = 2;
    localparam int DW      = N * 8;
    localparam int RW      = 16 + 3 * DW;
    localparam int BPB     = 32;
    localparam int BPS     = 64;
    localparam int BPF     = 128;

    logic         clk;
    logic         rst_n;
    logic         enable;
    logic         stripe_done;
    logic         frame_done;
    logic         busy;
    logic         err_credit;
    sched_state_e dbg_state;

    blk_stripe_scheduler_if #(.N(N)) bus ();

    blk_stripe_scheduler #(
        .N       (N),
        .X_RES   (X_RES),
        .Y_RES   (Y_RES),
        .CREDITS (CREDITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus),
        .stripe_done (stripe_done),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_credit  (err_credit),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // ---------------- scoreboard ----------------
    // exp_q: accepted beats stamped with the cycle their copy must appear.
    // got_q: observed output beats stamped with the cycle they appeared.
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] got_q[$];
    logic [2:0]    flag_q[$];
    int            acc_cyc_q[$];
    int            fd_cnt;
    int            fd_cyc;
    int            stray_cnt;
    int            n_checks;
    int            n_pass;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back({16'(cyc + 1), bus.in_data_cb, bus.in_data_cr, bus.in_data_y});
                acc_cyc_q.push_back(cyc);
            end
            if (bus.blk_valid) begin
                got_q.push_back({16'(cyc), bus.blk_data_cb, bus.blk_data_cr, bus.blk_data_y});
                flag_q.push_back({bus.blk_sof, bus.blk_sob, bus.blk_eob});
            end else if (bus.blk_sof || bus.blk_sob || bus.blk_eob) begin
                stray_cnt++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
        end
    end

    function automatic int count_data_errs();
        int errs = 0;
        int n    = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        if (got_q.size() != exp_q.size()) errs++;
        for (int k = 0; k < n; k++) begin
            if (got_q[k] !== exp_q[k]) errs++;
        end
        return errs;
    endfunction

    function automatic int count_flag_errs();
        int errs = 0;
        for (int k = 0; k < flag_q.size(); k++) begin
            logic [2:0] want;
            want = {((k % BPF) == 0), ((k % BPB) == 0), ((k % BPB) == BPB - 1)};
            if (flag_q[k] !== want) errs++;
        end
        return errs;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.in_data_y  = DW'($urandom);
        bus.in_data_cr = DW'($urandom);
        bus.in_data_cb = DW'($urandom);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        flag_q.delete();
        acc_cyc_q.delete();
        fd_cnt    = 0;
        fd_cyc    = -1;
        stray_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        stripe_done  = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        clear_sb();
    endtask

    task automatic pulse_stripe_done();
        stripe_done = 1'b1;
        tick();
        stripe_done = 1'b0;
    endtask

    task automatic wait_acc(input int target, input int budget, output bit ok);
        int n = 0;
        while (exp_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        ok = (exp_q.size() >= target);
    endtask

    task automatic wait_fd(input int budget, output bit ok);
        int n = 0;
        while (fd_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        ok = (fd_cnt != 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        stripe_done  = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) tick();
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.blk_valid !== 1'b0) $display("FAIL rst_blk_valid got %0b want 0", bus.blk_valid); else n_pass++;
        n_checks++; if ({bus.blk_sof, bus.blk_sob, bus.blk_eob} !== 3'b000)
            $display("FAIL rst_markers got %03b want 000", {bus.blk_sof, bus.blk_sob, bus.blk_eob}); else n_pass++;
        n_checks++; if (bus.blk_data_y !== '0) $display("FAIL rst_blk_data_y got %h want 0", bus.blk_data_y); else n_pass++;
        n_checks++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %0b want 0", frame_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (err_credit !== 1'b0) $display("FAIL rst_err_credit got %0b want 0", err_credit); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL rst_state got %0d want %0d", dbg_state, IDLE); else n_pass++;
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_no_enable_busy got %0b want 0", busy); else n_pass++;
    endtask

    task automatic test_full_frame();
        bit ok;
        int gaps;
        int want_fd;
        int gap_mid;
        do_reset();
        enable       = 1'b1;
        bus.in_valid = 1'b1;
        wait_fd(400, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL full_frame_timeout got %0b want 1", ok); else n_pass++;
        repeat (3) tick();
        n_checks++; if (got_q.size() !== BPF) $display("FAIL full_frame_beats got %0d want %0d", got_q.size(), BPF); else n_pass++;
        n_checks++; if (count_data_errs() !== 0) $display("FAIL full_frame_data got %0d errs want 0", count_data_errs()); else n_pass++;
        n_checks++; if (count_flag_errs() !== 0) $display("FAIL full_frame_markers got %0d errs want 0", count_flag_errs()); else n_pass++;
        n_checks++; if (stray_cnt !== 0) $display("FAIL full_frame_stray_markers got %0d want 0", stray_cnt); else n_pass++;
        want_fd = (acc_cyc_q.size() >= BPF) ? acc_cyc_q[BPF-1] + 2 : -2;
        n_checks++; if (fd_cyc !== want_fd) $display("FAIL frame_done_cycle got %0d want %0d", fd_cyc, want_fd); else n_pass++;
        gaps = 0;
        for (int k = 1; k < acc_cyc_q.size(); k++) begin
            if (k != BPS && acc_cyc_q[k] - acc_cyc_q[k-1] != 1) gaps++;
        end
        n_checks++; if (gaps !== 0) $display("FAIL full_frame_stalls got %0d want 0", gaps); else n_pass++;
        gap_mid = (acc_cyc_q.size() > BPS) ? acc_cyc_q[BPS] - acc_cyc_q[BPS-1] : -1;
        n_checks++; if (gap_mid !== 2) $display("FAIL stripe_boundary_gap got %0d want 2", gap_mid); else n_pass++;
        repeat (20) tick();
        n_checks++; if (exp_q.size() !== BPF) $display("FAIL no_credit_accepts got %0d want %0d", exp_q.size(), BPF); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL no_credit_in_ready got %0b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (dbg_state !== WAIT_CREDIT) $display("FAIL no_credit_state got %0d want %0d", dbg_state, WAIT_CREDIT); else n_pass++;
        n_checks++; if (fd_cnt !== 1) $display("FAIL frame_done_pulses got %0d want 1", fd_cnt); else n_pass++;
    endtask

    // Continues directly from test_full_frame with zero credits left.
    task automatic test_credit_resume();
        bit ok;
        clear_sb();
        pulse_stripe_done();
        wait_acc(BPS, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL resume_stripe0_timeout got %0b want 1", ok); else n_pass++;
        repeat (10) tick();
        n_checks++; if (exp_q.size() !== BPS) $display("FAIL resume_stall_accepts got %0d want %0d", exp_q.size(), BPS); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL resume_stall_in_ready got %0b want 0", bus.in_ready); else n_pass++;
        pulse_stripe_done();
        wait_fd(300, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL resume_frame_timeout got %0b want 1", ok); else n_pass++;
        repeat (3) tick();
        n_checks++; if (got_q.size() !== BPF) $display("FAIL resume_beats got %0d want %0d", got_q.size(), BPF); else n_pass++;
        n_checks++; if (flag_q[BPS] !== 3'b010) $display("FAIL resume_stripe1_sob got %03b want 010", flag_q[BPS]); else n_pass++;
        n_checks++; if (count_flag_errs() !== 0) $display("FAIL resume_markers got %0d errs want 0", count_flag_errs()); else n_pass++;
        n_checks++; if (count_data_errs() !== 0) $display("FAIL resume_data got %0d errs want 0", count_data_errs()); else n_pass++;
    endtask

    task automatic test_stall_latency();
        bit ok;
        int s0;
        int s1;
        do_reset();
        enable       = 1'b1;
        bus.in_valid = 1'b1;
        wait_acc(20, 100, ok);
        s0 = exp_q.size();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = ((i % 2) == 0);
            tick();
        end
        s1 = exp_q.size();
        bus.in_valid = 1'b1;
        n_checks++; if (s1 - s0 !== 8) $display("FAIL stall_accepts got %0d want 8", s1 - s0); else n_pass++;
        wait_fd(400, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL stall_frame_timeout got %0b want 1", ok); else n_pass++;
        repeat (3) tick();
        n_checks++; if (got_q.size() !== BPF) $display("FAIL stall_beats got %0d want %0d", got_q.size(), BPF); else n_pass++;
        n_checks++; if (count_data_errs() !== 0) $display("FAIL stall_data_latency got %0d errs want 0", count_data_errs()); else n_pass++;
        n_checks++; if (count_flag_errs() !== 0) $display("FAIL stall_markers got %0d errs want 0", count_flag_errs()); else n_pass++;
        n_checks++; if (stray_cnt !== 0) $display("FAIL stall_stray_markers got %0d want 0", stray_cnt); else n_pass++;
    endtask

    task automatic test_credit_edges();
        bit ok;
        int n;
        // stripe_done while all credits are held
        do_reset();
        pulse_stripe_done();
        tick();
        n_checks++; if (err_credit !== 1'b1) $display("FAIL overflow_err got %0b want 1", err_credit); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL overflow_state got %0d want %0d", dbg_state, IDLE); else n_pass++;
        enable       = 1'b1;
        bus.in_valid = 1'b1;
        wait_fd(400, ok);
        repeat (20) tick();
        n_checks++; if (exp_q.size() !== BPF) $display("FAIL overflow_credit_hold got %0d want %0d", exp_q.size(), BPF); else n_pass++;
        n_checks++; if (err_credit !== 1'b1) $display("FAIL overflow_sticky got %0b want 1", err_credit); else n_pass++;

        // stripe_done in the same cycle a credit is claimed
        do_reset();
        enable       = 1'b1;
        bus.in_valid = 1'b1;
        n = 0;
        while (!(dbg_state == WAIT_CREDIT && exp_q.size() >= BPS) && n < 200) begin
            tick();
            n++;
        end
        n_checks++; if (dbg_state !== WAIT_CREDIT) $display("FAIL coincide_reach got %0d want %0d", dbg_state, WAIT_CREDIT); else n_pass++;
        pulse_stripe_done();
        wait_acc(BPF + BPS, 600, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL coincide_timeout got %0b want 1", ok); else n_pass++;
        repeat (20) tick();
        n_checks++; if (exp_q.size() !== BPF + BPS) $display("FAIL coincide_accepts got %0d want %0d", exp_q.size(), BPF + BPS); else n_pass++;
        n_checks++; if (err_credit !== 1'b0) $display("FAIL coincide_err got %0b want 0", err_credit); else n_pass++;
        n_checks++; if (count_flag_errs() !== 0) $display("FAIL coincide_markers got %0d errs want 0", count_flag_errs()); else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit ok2;
        do_reset();
        enable       = 1'b1;
        bus.in_valid = 1'b1;
        wait_acc(40, 200, ok);
        enable = 1'b0;
        wait_fd(400, ok2);
        n_checks++; if ((ok && ok2) !== 1'b1) $display("FAIL enable_drop_timeout got %0b want 1", ok && ok2); else n_pass++;
        repeat (5) tick();
        n_checks++; if (exp_q.size() !== BPF) $display("FAIL enable_drop_beats got %0d want %0d", exp_q.size(), BPF); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL enable_drop_busy got %0b want 0", busy); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL enable_drop_state got %0d want %0d", dbg_state, IDLE); else n_pass++;
        n_checks++; if (count_flag_errs() !== 0) $display("FAIL enable_drop_markers got %0d errs want 0", count_flag_errs()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        do_reset();
        enable       = 1'b1;
        bus.in_valid = 1'b1;
        wait_acc(70, 200, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL midrst_reach got %0b want 1", ok); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.blk_valid, bus.blk_sof, bus.blk_sob, bus.blk_eob} !== 4'b0000)
            $display("FAIL midrst_blk_outputs got %04b want 0000", {bus.blk_valid, bus.blk_sof, bus.blk_sob, bus.blk_eob}); else n_pass++;
        n_checks++; if ({bus.blk_data_y, bus.blk_data_cr, bus.blk_data_cb} !== '0)
            $display("FAIL midrst_blk_data got %h want 0", {bus.blk_data_y, bus.blk_data_cr, bus.blk_data_cb}); else n_pass++;
        n_checks++; if ({bus.in_ready, busy, frame_done, err_credit} !== 4'b0000)
            $display("FAIL midrst_ctrl_outputs got %04b want 0000", {bus.in_ready, busy, frame_done, err_credit}); else n_pass++;
        n_checks++; if (dbg_state !== IDLE) $display("FAIL midrst_state got %0d want %0d", dbg_state, IDLE); else n_pass++;
        tick();
        rst_n = 1'b1;
        clear_sb();
        wait_fd(400, ok);
        repeat (3) tick();
        n_checks++; if (flag_q[0] !== 3'b110) $display("FAIL midrst_first_beat got %03b want 110", flag_q[0]); else n_pass++;
        n_checks++; if (got_q.size() !== BPF) $display("FAIL midrst_next_frame_beats got %0d want %0d", got_q.size(), BPF); else n_pass++;
        n_checks++; if (count_flag_errs() !== 0) $display("FAIL midrst_markers got %0d errs want 0", count_flag_errs()); else n_pass++;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_checks       = 0;
        n_pass         = 0;
        fd_cnt         = 0;
        fd_cyc         = -1;
        stray_cnt      = 0;
        rst_n          = 1'b0;
        enable         = 1'b0;
        stripe_done    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data_y  = '0;
        bus.in_data_cr = '0;
        bus.in_data_cb = '0;

        test_reset();
        test_full_frame();
        test_credit_resume();
        test_stall_latency();
        test_credit_edges();
        test_enable_drop();
        test_reset_mid_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
